button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//  Consumes the debounced level of one push-button debouncer and turns it into
//  single-cycle user events: press, release, long-press and auto-repeat, plus a
//  normalised held level and a saturating hold-time in ms. Sits directly
//  downstream of the debouncer; its pulses feed the camera control register block.
// PARAMETERS
//  FREQ_KHZ         100000  clk frequency in kHz (clk cycles per ms)
//  XPOL             1       rest (released) level of xDeb; pressed = !XPOL
//  LONG_MS          1000    hold time in ms that fires long_pulse (>=1)
//  REPEAT_DELAY_MS  500     hold time in ms of first repeat_pulse (>=1)
//  REPEAT_MS        100     period in ms of subsequent repeat_pulse (>=1)
//  HOLD_W           16      width of hold_ms counter
// PORTS
//  clk            in   1       system clock, single clock domain
//  rst            in   1       asynchronous, active-low reset
//  xDeb           in   1       debounced button level, synchronous to clk
//  pressed        out  1       1 while button held (polarity-normalised)
//  press_pulse    out  1       1-cycle pulse on press
//  release_pulse  out  1       1-cycle pulse on release
//  long_pulse     out  1       1-cycle pulse, once per press, at LONG_MS
//  repeat_pulse   out  1       1-cycle pulses at REPEAT_DELAY_MS, then every REPEAT_MS
//  hold_ms        out  HOLD_W  ms elapsed since press; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, state INIT, prescaler/counters 0.
//  - p = (xDeb != XPOL), sampled every clk. All outputs are registered.
//  - States: INIT, IDLE, HELD.
//    INIT: first clk after reset release; p=0 -> IDLE, p=1 -> WAIT_REL
//      (sub-flag of IDLE): a button already held at reset gives no press_pulse,
//      no release_pulse, pressed stays 0 until a real release then press.
//    IDLE: p=1 -> HELD; press_pulse=1 and pressed=1 in the next cycle (T).
//    HELD: p=0 -> IDLE; release_pulse=1, pressed=0 next cycle; hold_ms and
//      repeat state cleared in the same cycle.
//  - Timing in HELD (T = cycle press_pulse is 1): prescaler restarts at press,
//    hold_ms increments at T + k*FREQ_KHZ, k=1,2,...; saturates, never wraps.
//  - long_pulse: cycle hold_ms becomes LONG_MS, i.e. T + LONG_MS*FREQ_KHZ;
//    once per press even if hold_ms saturates.
//  - repeat_pulse: at T + REPEAT_DELAY_MS*FREQ_KHZ, then every REPEAT_MS*FREQ_KHZ
//    while held; repeat counter independent of hold_ms saturation.
//  - long_pulse and repeat_pulse may coincide (both 1 same cycle).
//  - Release sampled in the same cycle a long/repeat would fire: release wins,
//    no long/repeat pulse emitted.
//  - Re-press in the cycle after release_pulse: legal, full new sequence.
//  - press_pulse/release_pulse never asserted in the same cycle.
//  - Reset asserted mid-press: outputs drop to 0 immediately (async), no
//    release_pulse; after reset, INIT rule applies.
// STRUCTURE
//  - button_pkg: state enum {INIT, IDLE, HELD}; localparam-style function
//    giving prescaler width clog2(FREQ_KHZ); repeat counter width
//    clog2(max(REPEAT_DELAY_MS, REPEAT_MS)+1).
//  - Sub-module ms_tick_gen: cycle prescaler with sync clear, emits 1-cycle
//    tick every FREQ_KHZ cycles; instantiated once, cleared on press.
//  - Top: input register, FSM, hold_ms counter, repeat countdown, output regs.
// TESTING  (FREQ_KHZ=10, XPOL=1, LONG_MS=5, REPEAT_DELAY_MS=3, REPEAT_MS=2)
//  - Reset with xDeb=1, then xDeb=0 at cycle 0 -> press_pulse at cycle 1,
//    pressed=1 from cycle 1, hold_ms=1 at cycle 11.
//  - Hold 80 cycles -> repeat_pulse at T+30, T+50, T+70; long_pulse only at T+50
//    (coincides with repeat); hold_ms=8 at T+80.
//  - Release at T+29 (sampled before first repeat) -> release_pulse one cycle
//    later, no repeat/long pulse, hold_ms=0, pressed=0.
//  - Hold xDeb=0 across reset release -> no press_pulse; release then press
//    -> exactly one release-less re-arm, one press_pulse on the new press.
//  - Assert rst mid-hold at T+40 -> all outputs 0 asynchronously, no
//    release_pulse ever emitted for that press.
//  - HOLD_W=4, hold 200 cycles -> hold_ms saturates at 15, repeats continue
//    every 20 cycles, long_pulse fired exactly once.

Source files
------------

// File: rtl/button_event_gen_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the button event generator: FSM state encodings and
//   constant helper functions that size the prescaler and repeat countdown.
// -----------------------------------------------------------------------------
package button_pkg;

  // FSM states (plain constants so legacy tools see a fixed encoding)
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  typedef logic [1:0] state_t;

  // Bits needed to hold 0..value-1; never less than 1 so a degenerate
  // parameter still yields a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((64'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Repeat countdown must hold the larger of the two reload values.
  function automatic int repeat_width(input int delay_ms, input int period_ms);
    return clog2_min1(max_int(delay_ms, period_ms) + 1);
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// -----------------------------------------------------------------------------
// button_event_gen_if
//   Bundles the debounced button input and the event outputs.
//   master : drives xDeb, observes events (upstream / bench side)
//   slave  : consumes xDeb, drives events (button_event_gen side)
//   Signals: xDeb, pressed, press_pulse, release_pulse, long_pulse,
//            repeat_pulse, hold_ms[HOLD_W-1:0]
// -----------------------------------------------------------------------------
interface button_event_gen_if #(
  parameter int HOLD_W = 16
);
  logic              xDeb;
  logic              pressed;
  logic              press_pulse;
  logic              release_pulse;
  logic              long_pulse;
  logic              repeat_pulse;
  logic [HOLD_W-1:0] hold_ms;

  modport master (
    output xDeb,
    input  pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_ms
  );

  modport slave (
    input  xDeb,
    output pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_ms
  );
endinterface

// File: rtl/button_event_gen_ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
//   Cycle prescaler producing a one-cycle tick every FREQ_KHZ clocks (1 ms).
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear, holds the count at 0 while asserted
//   tick : 1-cycle pulse on the last cycle of each ms period
// -----------------------------------------------------------------------------
module ms_tick_gen
  import button_pkg::*;
#(
  parameter int FREQ_KHZ = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int          PW   = clog2_min1(FREQ_KHZ);
  localparam logic [PW-1:0] LAST = PW'(FREQ_KHZ - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt_r;

  // Prescaler count: wraps at LAST, forced to 0 by clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  // Tick is combinational so the consumer's registered update lands exactly
  // FREQ_KHZ cycles after the clear is released.
  assign tick = (!clr) && (cnt_r == LAST);

endmodule

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//   Turns one debounced button level into registered single-cycle events:
//   press, release, long-press and auto-repeat, plus a normalised held level
//   and a saturating hold time in ms.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : button_event_gen_if.slave (xDeb in; pressed, press_pulse,
//         release_pulse, long_pulse, repeat_pulse, hold_ms out)
// -----------------------------------------------------------------------------
module button_event_gen
  import button_pkg::*;
#(
  parameter int FREQ_KHZ        = 100000,
  parameter bit XPOL            = 1'b1,
  parameter int LONG_MS         = 1000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100,
  parameter int HOLD_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  button_event_gen_if.slave  bus
);

  localparam int              RW         = repeat_width(REPEAT_DELAY_MS, REPEAT_MS);
  localparam logic [RW-1:0]   REP_DELAY  = RW'(REPEAT_DELAY_MS);
  localparam logic [RW-1:0]   REP_PERIOD = RW'(REPEAT_MS);
  localparam logic [RW-1:0]   REP_ONE    = RW'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam int              LONG_M1    = LONG_MS - 1;

  state_t            state_r;
  logic              wait_rel_r;   // held at reset: ignore until a real release
  logic [HOLD_W-1:0] hold_r;
  logic [RW-1:0]     rep_r;
  logic              long_done_r;
  logic              pressed_r;
  logic              press_r;
  logic              release_r;
  logic              long_r;
  logic              repeat_r;

  logic              p_s;
  logic              clr_s;
  logic              tick_s;
  logic              long_hit_s;

  assign p_s   = (bus.xDeb != XPOL);
  // Prescaler only runs while a press is held; clearing in IDLE makes it
  // restart from 0 on the press edge.
  assign clr_s = (state_r != ST_HELD) || (!p_s);
  // Long fires on the tick that moves hold_ms onto LONG_MS.
  assign long_hit_s = (32'(hold_r) == 32'(LONG_M1));

  ms_tick_gen #(
    .FREQ_KHZ (FREQ_KHZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // FSM, hold counter, repeat countdown and registered event outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_INIT;
      wait_rel_r  <= 1'b0;
      hold_r      <= '0;
      rep_r       <= '0;
      long_done_r <= 1'b0;
      pressed_r   <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      long_r      <= 1'b0;
      repeat_r    <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      case (state_r)
        ST_INIT: begin
          wait_rel_r <= p_s;
          state_r    <= ST_IDLE;
        end
        ST_IDLE: begin
          if (wait_rel_r) begin
            if (!p_s) begin
              wait_rel_r <= 1'b0;
            end
          end else if (p_s) begin
            state_r     <= ST_HELD;
            press_r     <= 1'b1;
            pressed_r   <= 1'b1;
            hold_r      <= '0;
            rep_r       <= REP_DELAY;
            long_done_r <= 1'b0;
          end
        end
        ST_HELD: begin
          if (!p_s) begin
            // Release takes priority over any long/repeat due this cycle.
            state_r     <= ST_IDLE;
            release_r   <= 1'b1;
            pressed_r   <= 1'b0;
            hold_r      <= '0;
            rep_r       <= '0;
            long_done_r <= 1'b0;
          end else if (tick_s) begin
            if (hold_r != HOLD_MAX) begin
              hold_r <= hold_r + HOLD_ONE;
            end
            // long_done keeps it to one pulse even if hold_ms parks at the
            // compare value after saturating.
            if (!long_done_r && long_hit_s) begin
              long_r      <= 1'b1;
              long_done_r <= 1'b1;
            end
            if (rep_r == REP_ONE) begin
              repeat_r <= 1'b1;
              rep_r    <= REP_PERIOD;
            end else begin
              rep_r <= rep_r - REP_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.pressed       = pressed_r;
  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.long_pulse    = long_r;
  assign bus.repeat_pulse  = repeat_r;
  assign bus.hold_ms       = hold_r;

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
//   Directed bench: FREQ_KHZ=10, XPOL=1, LONG_MS=5, REPEAT_DELAY_MS=3,
//   REPEAT_MS=2, HOLD_W=4. Inputs change and outputs are sampled on the
//   falling edge; t counts cycles from the cycle press_pulse is high.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

  localparam int HW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  button_event_gen_if #(.HOLD_W(HW)) bus ();

  button_event_gen #(
    .FREQ_KHZ        (10),
    .XPOL            (1'b1),
    .LONG_MS         (5),
    .REPEAT_DELAY_MS (3),
    .REPEAT_MS       (2),
    .HOLD_W          (HW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_outs(input string tag, input logic pr, input logic pp,
                             input logic rp, input logic lp, input logic rpt,
                             input int hm);
    check({tag, " pressed"},       32'(bus.pressed),       32'(pr));
    check({tag, " press_pulse"},   32'(bus.press_pulse),   32'(pp));
    check({tag, " release_pulse"}, 32'(bus.release_pulse), 32'(rp));
    check({tag, " long_pulse"},    32'(bus.long_pulse),    32'(lp));
    check({tag, " repeat_pulse"},  32'(bus.repeat_pulse),  32'(rpt));
    check({tag, " hold_ms"},       32'(bus.hold_ms),       32'(hm));
  endtask

  // Checks cycles t=0..ncyc-1 of a held press; returns at falling edge of t=ncyc.
  // Hand-derived schedule: hold_ms = t/10 capped at 15, repeats at t=30,50,70,...,
  // long only at t=50.
  task automatic watch_hold(input string tag, input int ncyc);
    int hm;
    for (int t = 0; t < ncyc; t++) begin
      hm = t / 10;
      if (hm > 15) hm = 15;
      expect_outs($sformatf("%s t=%0d", tag, t), 1'b1, (t == 0), 1'b0,
                  (t == 50), ((t >= 30) && (((t - 30) % 20) == 0)), hm);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset with button released
    bus.xDeb = 1'b1;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Press and hold 80 cycles, then release
    bus.xDeb = 1'b0;
    @(negedge clk);
    watch_hold("hold80", 81);
    bus.xDeb = 1'b1;
    @(negedge clk);
    expect_outs("rel80", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    expect_outs("rel80+1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Release sampled on the edge the first repeat would fire
    bus.xDeb = 1'b0;
    @(negedge clk);
    watch_hold("early", 29);
    bus.xDeb = 1'b1;
    @(negedge clk);
    expect_outs("early rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Immediate re-press, held long enough for hold_ms to saturate
    bus.xDeb = 1'b0;
    @(negedge clk);
    watch_hold("sat", 201);
    bus.xDeb = 1'b1;
    @(negedge clk);
    expect_outs("sat rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);

    // Button held across reset release: no events until a real release+press
    rst      = 1'b0;
    bus.xDeb = 1'b0;
    #1;
    expect_outs("rst held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_outs($sformatf("held-at-reset %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    bus.xDeb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_outs($sformatf("rearm %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    bus.xDeb = 1'b0;
    @(negedge clk);
    watch_hold("rearm", 40);

    // Reset mid-hold at t=40
    expect_outs("pre-rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    #1;
    rst = 1'b0;
    #1;
    expect_outs("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      expect_outs($sformatf("post-rst %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    bus.xDeb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_outs($sformatf("post-rst rel %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
